// File: rtl/grad_dac_sched.sv
// grad_dac_sched: round-robin scheduler feeding four gradient DAC channels
// (X, Y, Z, Z2) into one SPI serialiser. Each channel has a one-deep
// latest-value slot. A grant issues one valid-pulsed word, then the
// scheduler waits out the serialiser's busy handshake and a guard gap.
// Optional feature macro: GRAD_DAC_SCHED_STATS_EN (adds ovr_cnt_o, xfer_cnt_o).
module grad_dac_sched #(
    parameter int unsigned BUSY_TIMEOUT = 256,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  wr_i,
    input  logic [63:0] wdata_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    input  logic        busy_i,
    output logic [3:0]  pending_o,
    output logic        idle_o,
    output logic        err_timeout_o,
    output logic [1:0]  err_chan_o,
    input  logic        clr_err_i
`ifdef GRAD_DAC_SCHED_STATS_EN
    ,
    output logic [15:0] ovr_cnt_o,
    output logic [15:0] xfer_cnt_o
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_GUARD} state_e;

    localparam logic [15:0] TMO_LAST  = 16'(BUSY_TIMEOUT - 1);
    localparam logic [4:0]  GUARD_LEN = 5'(GUARD_CYCLES);

    state_e           state_q, state_d;
    logic [3:0][15:0] slot_q;
    logic [3:0]       pend_q, pend_d, pend_clr;
    logic [1:0]       rr_q, rr_d;
    logic [1:0]       gchan_q, gchan_d;
    logic [31:0]      data_q, data_d;
    logic [15:0]      tcnt_q, tcnt_d;
    logic [3:0]       gcnt_q, gcnt_d;
    logic             err_q, err_d;
    logic [1:0]       echan_q, echan_d;
    logic             tmo;
    logic             gnt_vld;
    logic [1:0]       gnt_ch, gnt_idx;
`ifdef GRAD_DAC_SCHED_STATS_EN
    logic             xfer_done;
`endif

    // First pending channel at or after the RR pointer; scan farthest offset
    // first so the nearest pending channel is the last (winning) assignment.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = rr_q;
        gnt_idx = rr_q;
        for (int i = 3; i >= 0; i--) begin
            gnt_idx = rr_q + 2'(i);
            if (pend_q[gnt_idx]) begin
                gnt_vld = 1'b1;
                gnt_ch  = gnt_idx;
            end
        end
    end

    // Next-state and output decode for the grant/handshake sequence.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gchan_d  = gchan_q;
        data_d   = data_q;
        tcnt_d   = tcnt_q;
        gcnt_d   = gcnt_q;
        pend_clr = 4'b0;
        tmo      = 1'b0;
        valid_o  = 1'b0;
`ifdef GRAD_DAC_SCHED_STATS_EN
        xfer_done = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // Serialiser may be owned by someone else: hold off while busy.
                if (gnt_vld && !busy_i) begin
                    data_d           = {5'b0, gnt_ch, 1'b0, 8'b0, slot_q[gnt_ch]};
                    pend_clr[gnt_ch] = 1'b1;
                    rr_d             = gnt_ch + 2'd1;
                    gchan_d          = gnt_ch;
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                valid_o = 1'b1;
                tcnt_d  = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (busy_i) begin
                    state_d = S_WAIT_DONE;
                end else if (tcnt_q == TMO_LAST) begin
                    tmo     = 1'b1;
                    gcnt_d  = '0;
                    state_d = S_GUARD;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!busy_i) begin
                    gcnt_d  = '0;
                    state_d = S_GUARD;
`ifdef GRAD_DAC_SCHED_STATS_EN
                    xfer_done = 1'b1;
`endif
                end
            end
            S_GUARD: begin
                // Always at least one cycle here, GUARD_CYCLES when larger.
                if ({1'b0, gcnt_q} + 5'd1 >= GUARD_LEN) state_d = S_IDLE;
                else                                     gcnt_d  = gcnt_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Slot flags: a same-edge write beats the grant's clear.
    always_comb begin
        pend_d  = (pend_q & ~pend_clr) | wr_i;
        err_d   = err_q;
        echan_d = echan_q;
        if (tmo) begin
            err_d   = 1'b1;
            echan_d = gchan_q;
        end else if (clr_err_i) begin
            err_d   = 1'b0;
            echan_d = 2'd0;
        end
    end

    // State, slot and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            pend_q  <= '0;
            rr_q    <= '0;
            gchan_q <= '0;
            data_q  <= '0;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            err_q   <= 1'b0;
            echan_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
            gchan_q <= gchan_d;
            data_q  <= data_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            err_q   <= err_d;
            echan_q <= echan_d;
            for (int n = 0; n < 4; n++)
                if (wr_i[n]) slot_q[n] <= wdata_i[16*n +: 16];
        end
    end

    assign data_o        = data_q;
    assign pending_o     = pend_q;
    assign idle_o        = (state_q == S_IDLE) && (pend_q == 4'b0);
    assign err_timeout_o = err_q;
    assign err_chan_o    = echan_q;

`ifdef GRAD_DAC_SCHED_STATS_EN
    logic [15:0] ovr_q, xfer_q;
    logic [16:0] ovr_sum;

    // Overwrites of a still-pending slot; a slot cleared by a same-edge grant
    // is not pending any more, so that write does not count.
    assign ovr_sum = {1'b0, ovr_q} + 17'($countones(wr_i & pend_q & ~pend_clr));

    // Statistics counters: overwrite count saturates, transfer count wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q  <= '0;
            xfer_q <= '0;
        end else if (clr_err_i) begin
            ovr_q  <= '0;
            xfer_q <= '0;
        end else begin
            ovr_q  <= ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];
            if (xfer_done) xfer_q <= xfer_q + 16'd1;
        end
    end

    assign ovr_cnt_o  = ovr_q;
    assign xfer_cnt_o = xfer_q;
`endif

endmodule

// File: tb/tb_grad_dac_sched.sv
// Self-checking bench for grad_dac_sched: directed scenarios plus a random
// phase, all checked against a transaction-level slot/round-robin model.
module tb_grad_dac_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  wr_i = '0;
    logic [63:0] wdata_i = '0;
    logic        busy_i;
    logic        clr_err_i = 1'b0;
    logic [31:0] data_o;
    logic        valid_o;
    logic [3:0]  pending_o;
    logic        idle_o;
    logic        err_timeout_o;
    logic [1:0]  err_chan_o;
`ifdef GRAD_DAC_SCHED_STATS_EN
    logic [15:0] ovr_cnt_o, xfer_cnt_o;
`endif

    grad_dac_sched #(.BUSY_TIMEOUT(8), .GUARD_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .wr_i(wr_i), .wdata_i(wdata_i),
        .data_o(data_o), .valid_o(valid_o), .busy_i(busy_i),
        .pending_o(pending_o), .idle_o(idle_o),
        .err_timeout_o(err_timeout_o), .err_chan_o(err_chan_o),
        .clr_err_i(clr_err_i)
`ifdef GRAD_DAC_SCHED_STATS_EN
        , .ovr_cnt_o(ovr_cnt_o), .xfer_cnt_o(xfer_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Serialiser model: busy rises two cycles after a valid, lasts blen cycles.
    bit   auto_en = 1'b0;
    bit   busy_force = 1'b0;
    int   blen = 3;
    int   rc = 0;
    logic rb = 1'b0;
    assign busy_i = busy_force | rb;

    always @(posedge clk) begin
        if (!auto_en) begin
            rc <= 0; rb <= 1'b0;
        end else if (valid_o) begin
            rc <= 1; rb <= 1'b0;
        end else if (rc != 0) begin
            rb <= (rc >= 2) && (rc < 2 + blen);
            rc <= (rc >= 2 + blen) ? 0 : rc + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model: latest value per channel, pending flags, RR pointer.
    logic [15:0] m_slot [4];
    logic [3:0]  m_pend = '0;
    int          m_rr = 0;
    logic [31:0] m_last = '0;
    int          m_ovr = 0;
    bit          prev_v = 1'b0;
    int          iss_ch [$];
    logic [15:0] iss_dat [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after each negedge: the writes on wr_i were taken at the
    // preceding posedge, and outputs show the state after that edge.
    task automatic sb();
        int  c;
        bit  found;
        if (!rst_n) begin
            m_pend = '0; m_rr = 0; m_last = '0; m_ovr = 0; prev_v = 1'b0;
            for (int n = 0; n < 4; n++) m_slot[n] = '0;
            return;
        end
        if (valid_o) begin
            chk("single_valid", 32'(prev_v), 32'd0);
            found = 1'b0; c = 0;
            for (int i = 0; i < 4; i++)
                if (!found && m_pend[(m_rr + i) % 4]) begin
                    c = (m_rr + i) % 4; found = 1'b1;
                end
            chk("grant_has_pending", 32'(found), 32'd1);
            m_last = (32'(c) << 25) | 32'(m_slot[c]);
            chk("grant_word", data_o, m_last);
            m_pend[c] = 1'b0;
            m_rr = (c + 1) % 4;
            iss_ch.push_back(c);
            iss_dat.push_back(m_slot[c]);
        end else begin
            chk("data_hold", data_o, m_last);
        end
        for (int n = 0; n < 4; n++)
            if (wr_i[n]) begin
                if (m_pend[n]) m_ovr = (m_ovr < 65535) ? m_ovr + 1 : 65535;
                m_pend[n] = 1'b1;
                m_slot[n] = wdata_i[16*n +: 16];
            end
        if (clr_err_i) m_ovr = 0;
        chk("pending", 32'(pending_o), 32'(m_pend));
`ifdef GRAD_DAC_SCHED_STATS_EN
        chk("ovr_cnt", 32'(ovr_cnt_o), 32'(m_ovr));
`endif
        prev_v = valid_o;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        sb();
    endtask

    task automatic wr(input logic [3:0] w, input logic [63:0] d);
        wr_i = w; wdata_i = d;
        step();
        wr_i = '0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (!(idle_o && pending_o == 4'b0) && n < lim) begin step(); n++; end
        chk("reach_idle", 32'(idle_o), 32'd1);
    endtask

    task automatic wait_busy(input int lim);
        int n = 0;
        while (!busy_i && n < lim) begin step(); n++; end
        chk("busy_seen", 32'(busy_i), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    function automatic int q_at(input int k);
        return (iss_ch.size() > k) ? iss_ch[k] : -1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int vcnt, n2;
        logic [15:0] d2;

        // Reset values
        @(negedge clk); sb();
        chk("rst_data", data_o, 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_pending", 32'(pending_o), 32'd0);
        chk("rst_idle", 32'(idle_o), 32'd1);
        chk("rst_err", 32'(err_timeout_o), 32'd0);
        chk("rst_chan", 32'(err_chan_o), 32'd0);
        rst_n = 1'b1;
        step();

        // Single write to channel 1: valid one cycle after the write edge
        auto_en = 1'b1; blen = 3;
        wr(4'b0010, 64'h0000_0000_1234_0000);
        chk("t1_pending", 32'(pending_o), 32'h2);
        step();
        chk("t1_valid", 32'(valid_o), 32'd1);
        chk("t1_word", data_o, 32'h0200_1234);
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin step(); if (valid_o) vcnt++; end
        chk("t1_extra_valid", 32'(vcnt), 32'd0);
        chk("t1_idle", 32'(idle_o), 32'd1);
        chk("t1_data_held", data_o, 32'h0200_1234);

        // All four at once -> 0,1,2,3; then 0 and 3 with pointer back at 0
        do_reset();
        iss_ch.delete(); iss_dat.delete();
        wr(4'b1111, 64'hDDDD_CCCC_BBBB_AAAA);
        for (int i = 0; i < 200 && !(iss_ch.size() == 4 && idle_o); i++) step();
        chk("t2_count", 32'(iss_ch.size()), 32'd4);
        for (int k = 0; k < 4; k++) chk("t2_order", 32'(q_at(k)), 32'(k));
        iss_ch.delete(); iss_dat.delete();
        wr(4'b1001, 64'h3333_0000_0000_0111);
        for (int i = 0; i < 200 && !(iss_ch.size() == 2 && idle_o); i++) step();
        chk("t2b_count", 32'(iss_ch.size()), 32'd2);
        chk("t2b_first", 32'(q_at(0)), 32'd0);
        chk("t2b_second", 32'(q_at(1)), 32'd3);

        // Channel 2 overwritten while channel 1 is busy: latest value only
        do_reset();
        iss_ch.delete(); iss_dat.delete();
        blen = 12;
        wr(4'b0010, 64'h0000_0000_1111_0000);
        wait_busy(20);
        wr(4'b0100, 64'h0000_0001_0000_0000);
        wr(4'b0100, 64'h0000_0002_0000_0000);
`ifdef GRAD_DAC_SCHED_STATS_EN
        chk("t3_ovr", 32'(ovr_cnt_o), 32'd1);
`endif
        wait_idle(200);
        n2 = 0; d2 = '0;
        for (int k = 0; k < iss_ch.size(); k++)
            if (iss_ch[k] == 2) begin n2++; d2 = iss_dat[k]; end
        chk("t3_ch2_count", 32'(n2), 32'd1);
        chk("t3_ch2_data", 32'(d2), 32'h0002);
`ifdef GRAD_DAC_SCHED_STATS_EN
        chk("t3_xfer", 32'(xfer_cnt_o), 32'd2);
`endif

        // Timeout: no busy at all on channel 3
        auto_en = 1'b0;
        step();
        wr(4'b1000, 64'hABCD_0000_0000_0000);
        step();
        chk("t4_valid", 32'(valid_o), 32'd1);
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i == 8) chk("t4_err_early", 32'(err_timeout_o), 32'd0);
            if (i == 9) begin
                chk("t4_err", 32'(err_timeout_o), 32'd1);
                chk("t4_chan", 32'(err_chan_o), 32'd3);
            end
        end
        wait_idle(20);
`ifdef GRAD_DAC_SCHED_STATS_EN
        chk("t4_xfer_unchanged", 32'(xfer_cnt_o), 32'd2);
`endif
        clr_err_i = 1'b1; step(); clr_err_i = 1'b0;
        chk("t4_clr_err", 32'(err_timeout_o), 32'd0);
        chk("t4_clr_chan", 32'(err_chan_o), 32'd0);

        // Reset during WAIT_DONE with two slots pending
        auto_en = 1'b1; blen = 20;
        wr(4'b0001, 64'h0000_0000_0000_5555);
        wait_busy(20);
        wr(4'b0110, 64'h0000_7777_6666_0000);
        step(); step();
        chk("t5_pending", 32'(pending_o), 32'h6);
        rst_n = 1'b0; auto_en = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(valid_o), 32'd0);
        chk("t5_rst_pending", 32'(pending_o), 32'd0);
        chk("t5_rst_idle", 32'(idle_o), 32'd1);
        chk("t5_rst_data", data_o, 32'd0);
        step(); step();
        rst_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 30; i++) begin step(); if (valid_o) vcnt++; end
        chk("t5_no_valid", 32'(vcnt), 32'd0);
        auto_en = 1'b1; blen = 3;
        wr(4'b0010, 64'h0000_0000_4242_0000);
        step();
        chk("t5_new_valid", 32'(valid_o), 32'd1);
        wait_idle(40);

        // Serialiser held busy before the write
        busy_force = 1'b1;
        step();
        wr(4'b0001, 64'h0000_0000_0000_0F0F);
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin step(); if (valid_o) vcnt++; end
        chk("t6_no_valid", 32'(vcnt), 32'd0);
        chk("t6_pending", 32'(pending_o), 32'h1);
        busy_force = 1'b0;
        step();
        chk("t6_valid", 32'(valid_o), 32'd1);
        wait_idle(40);

        // Random writes against the model
        blen = int'($urandom_range(1, 4));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3)
                wr(4'($urandom_range(1, 15)), {$urandom, $urandom});
            else
                step();
        end
        wait_idle(300);
        chk("rand_drained", 32'(pending_o), 32'd0);
        chk("rand_no_err", 32'(err_timeout_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
